argmax_row_scanner: RTL and testbench
=====================================

// Module: argmax_row_scanner
// PURPOSE
//   Sequential argmax controller for the GCN classification tail. It fetches
//   ADJ*FM*WM product rows one at a time through the argmax row buffer, scans
//   each buffered row column-by-column for its largest element, and writes the
//   winning column index back into the buffer's per-row result file.
//   It drives the buffer's is_read_row / is_increment_row_addr / max_value /
//   ADJ_FM_WM_ROW_Counter inputs and consumes the buffer's r_ADJ_FM_WM_Row.
// PARAMETERS
//   ADJ_DOT_PROD_WIDTH  16                   width of one product element
//   DOT_PROD_COLS       3                    elements (classes) per row
//   ARGMAX_ROWS         6                    rows (nodes) per frame
//   ARGMAX_COLS         2                    width of max_value; >= $clog2(DOT_PROD_COLS)
//   ARGMAX_WIDTH        $clog2(ARGMAX_ROWS)  width of the row counter
//   SIGNED_CMP          0                    1 = two's-complement compare, 0 = unsigned
// PORTS
//   clk                    in   1              single clock, rising edge
//   reset                  in   1              asynchronous, active-low (0 = reset)
//   start                  in   1              begin a frame; sampled only in IDLE
//   row_valid              in   1              upstream row on buffer input is valid and stable
//   r_ADJ_FM_WM_Row        in   W x COLS       registered row from the buffer
//   is_read_row            out  1              buffer capture/hold enable
//   is_increment_row_addr  out  1              one-cycle write strobe for the result
//   max_value              out  ARGMAX_COLS    argmax index of the current row
//   ADJ_FM_WM_ROW_Counter  out  ARGMAX_WIDTH   current row index
//   busy                   out  1              high in every state except IDLE
//   done                   out  1              one-cycle pulse when the frame completes
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE. All outputs are 0.
//     Internal best value, best index and column counter are 0.
//   - FSM: IDLE -> FETCH -> LOAD -> SCAN -> WRITE -> (FETCH | DONE) -> IDLE.
//   - IDLE: on start=1, clear the row counter to 0 and go to FETCH.
//   - FETCH: is_read_row=1. Stay while row_valid=0. On row_valid=1, go to LOAD.
//     The buffer captures the row at the end of this cycle.
//   - LOAD: is_read_row=1. best=r_row[0], best_idx=0, col=1.
//     Go to SCAN, or to WRITE if DOT_PROD_COLS==1.
//   - SCAN: is_read_row=1 throughout, because the buffer zeros its row when
//     is_read_row is low. Upstream must hold the row stable.
//     Each cycle: if r_row[col] > best (strictly greater), then
//     best=r_row[col] and best_idx=col. Ties keep the lowest index.
//     Compare is signed or unsigned per SIGNED_CMP.
//     col increments each cycle. Leave for WRITE after col==DOT_PROD_COLS-1.
//   - WRITE: is_read_row=0 and is_increment_row_addr=1 for exactly one cycle.
//     max_value=best_idx; ADJ_FM_WM_ROW_Counter=current row.
//     If row==ARGMAX_ROWS-1, go to DONE. Otherwise increment the row and go to FETCH.
//   - DONE: done=1 for one cycle, busy=1; then IDLE. The counter holds its last value.
//   - Row period with row_valid high: 1+1+(COLS-1)+1 cycles = 5 at defaults.
//     Each FETCH stall cycle adds one cycle.
//   - start is ignored in every state except IDLE.
//   - max_value holds its value between writes. It is guaranteed only while
//     is_increment_row_addr=1.
//   - The row counter never wraps inside a frame. It returns to 0 only on start or reset.
//   - Reset asserted mid-frame: immediate return to IDLE, all outputs 0, no
//     strobe or done is emitted. The next start begins at row 0.
// TESTING
//   1 Defaults, row_valid=1, rows {1,2,3},{9,0,0},{0,7,1},{4,4,8},{0,0,0},{2,5,5};
//     start at cycle 0 -> six strobes with max_value 2,0,1,2,0,1 and counter 0..5;
//     done at cycle 31.
//   2 Ties: {5,5,5} -> 0; {1,9,9} -> 1; {3,3,7} -> 2.
//   3 Row {FFFF,0001,8000}: SIGNED_CMP=0 -> 0; SIGNED_CMP=1 -> 1.
//   4 row_valid low for 3 cycles in FETCH of row 2 -> is_read_row stays 1,
//     no strobe, that row period is 8 cycles, result unchanged.
//   5 reset=0 during SCAN of row 3 -> all outputs 0 at once, no strobe or done;
//     restart -> first strobe has counter=0.
//   6 start pulsed in SCAN and in DONE -> ignored: one done, counter path unaffected.

Source files
------------

// File: rtl/argmax_row_scanner.sv
// ---------------------------------------------------------------------------
// argmax_row_scanner
//   Sequential argmax controller for the GCN classification tail. It pulls one
//   ADJ*FM*WM product row at a time through the external argmax row buffer,
//   walks the buffered row column by column to find its largest element, and
//   writes the winning column index back into the buffer's per-row result
//   file. Ties keep the lowest column index.
//
// Ports
//   clk                    in   rising-edge clock
//   reset                  in   asynchronous, active-low reset
//   start                  in   begin a frame (sampled only while idle)
//   row_valid              in   upstream row on the buffer input is valid
//   r_ADJ_FM_WM_Row        in   registered row from the buffer; element i sits
//                               at bits [i*W +: W]
//   is_read_row            out  buffer capture/hold enable
//   is_increment_row_addr  out  one-cycle result write strobe
//   max_value              out  argmax column index of the current row
//   ADJ_FM_WM_ROW_Counter  out  current row index
//   busy                   out  high whenever the controller is not idle
//   done                   out  one-cycle pulse at the end of a frame
//
// All outputs come straight from flops; they are computed from the next state
// so each output lines up with the state it describes.
// ---------------------------------------------------------------------------
module argmax_row_scanner #(
  parameter int ADJ_DOT_PROD_WIDTH = 16,
  parameter int DOT_PROD_COLS      = 3,
  parameter int ARGMAX_ROWS        = 6,
  parameter int ARGMAX_COLS        = 2,
  parameter int ARGMAX_WIDTH       = $clog2(ARGMAX_ROWS),
  parameter int SIGNED_CMP         = 0
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic                                         row_valid,
  input  logic [DOT_PROD_COLS*ADJ_DOT_PROD_WIDTH-1:0]  r_ADJ_FM_WM_Row,
  output logic                                         is_read_row,
  output logic                                         is_increment_row_addr,
  output logic [ARGMAX_COLS-1:0]                       max_value,
  output logic [ARGMAX_WIDTH-1:0]                      ADJ_FM_WM_ROW_Counter,
  output logic                                         busy,
  output logic                                         done
);

  localparam int W      = ADJ_DOT_PROD_WIDTH;
  localparam int COL_W  = ARGMAX_COLS;
  localparam int N_SLOT = 2 ** COL_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [COL_W-1:0]        LAST_COL = COL_W'(DOT_PROD_COLS - 1);
  localparam logic [ARGMAX_WIDTH-1:0] LAST_ROW = ARGMAX_WIDTH'(ARGMAX_ROWS - 1);

  // Strictly-greater compare; signedness fixed at elaboration.
  function automatic logic elem_gt(input logic [W-1:0] a, input logic [W-1:0] b);
    if (SIGNED_CMP != 0) begin
      return $signed(a) > $signed(b);
    end else begin
      return a > b;
    end
  endfunction

  // Row unpacked into a power-of-two slot array so any column counter value
  // indexes a defined slot; unused slots read as zero.
  logic [W-1:0] elem_s [N_SLOT];

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOT; gi++) begin : g_elem
      if (gi < DOT_PROD_COLS) begin : g_used
        assign elem_s[gi] = r_ADJ_FM_WM_Row[gi*W +: W];
      end else begin : g_unused
        assign elem_s[gi] = '0;
      end
    end
  endgenerate

  logic [2:0]              state_q, state_d;
  logic [ARGMAX_WIDTH-1:0] row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [W-1:0]            best_q, best_d;
  logic [COL_W-1:0]        best_idx_q, best_idx_d;
  logic [COL_W-1:0]        max_value_q, max_value_d;
  logic                    rd_q, rd_d;
  logic                    stb_q, stb_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Next-state logic for the fetch/load/scan/write sequence.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = '0;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (row_valid) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_LOAD: begin
        best_d     = elem_s[0];
        best_idx_d = '0;
        col_d      = COL_W'(1);
        if (DOT_PROD_COLS == 1) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Strictly greater only, so equal values keep the earlier column.
        if (elem_gt(elem_s[col_q], best_q)) begin
          best_d     = elem_s[col_q];
          best_idx_d = col_q;
        end else begin
          best_d     = best_q;
          best_idx_d = best_idx_q;
        end
        if (col_q == LAST_COL) begin
          state_d = S_WRITE;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = S_SCAN;
        end
      end
      S_WRITE: begin
        if (row_q == LAST_ROW) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + ARGMAX_WIDTH'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so registered outputs match the state.
  always_comb begin
    rd_d   = (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_SCAN);
    stb_d  = (state_d == S_WRITE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    if (state_d == S_WRITE) begin
      max_value_d = best_idx_d;
    end else begin
      max_value_d = max_value_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      max_value_q <= '0;
      rd_q        <= 1'b0;
      stb_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      max_value_q <= max_value_d;
      rd_q        <= rd_d;
      stb_q       <= stb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign is_read_row           = rd_q;
  assign is_increment_row_addr = stb_q;
  assign max_value             = max_value_q;
  assign ADJ_FM_WM_ROW_Counter = row_q;
  assign busy                  = busy_q;
  assign done                  = done_q;

endmodule

// File: tb/tb_argmax_row_scanner.sv
module tb_argmax_row_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        row_valid = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [47:0] tbl [6];

  // Instance A: unsigned compare
  logic [47:0] up_a, buf_a;
  logic        rd_a, stb_a, busy_a, done_a;
  logic [1:0]  mv_a;
  logic [2:0]  cnt_a;
  // Instance B: signed compare
  logic [47:0] up_b, buf_b;
  logic        rd_b, stb_b, busy_b, done_b;
  logic [1:0]  mv_b;
  logic [2:0]  cnt_b;

  // Per-cycle history of one frame run, indexed by cycle after start
  logic       h_rd [64];
  logic       h_stb [64];
  logic       h_busy [64];
  logic       h_done [64];
  logic [1:0] h_mv [64];
  logic [2:0] h_cnt [64];
  logic [1:0] h_mvb [64];
  logic       h_stbb [64];

  argmax_row_scanner #(.SIGNED_CMP(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .row_valid(row_valid),
    .r_ADJ_FM_WM_Row(buf_a), .is_read_row(rd_a), .is_increment_row_addr(stb_a),
    .max_value(mv_a), .ADJ_FM_WM_ROW_Counter(cnt_a), .busy(busy_a), .done(done_a)
  );

  argmax_row_scanner #(.SIGNED_CMP(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .row_valid(row_valid),
    .r_ADJ_FM_WM_Row(buf_b), .is_read_row(rd_b), .is_increment_row_addr(stb_b),
    .max_value(mv_b), .ADJ_FM_WM_ROW_Counter(cnt_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream presents the row addressed by the controller's counter;
  // the buffer captures while is_read_row is high and zeroes otherwise.
  assign up_a = tbl[cnt_a];
  assign up_b = tbl[cnt_b];
  always @(posedge clk) begin
    buf_a <= rd_a ? up_a : 48'd0;
    buf_b <= rd_b ? up_b : 48'd0;
  end

  function automatic logic [47:0] mk(input int a, input int b, input int c);
    logic [15:0] ea, eb, ec;
    ea = a[15:0];
    eb = b[15:0];
    ec = c[15:0];
    return {ec, eb, ea};
  endfunction

  task automatic load_main();
    tbl[0] = mk(1, 2, 3);  tbl[1] = mk(9, 0, 0);  tbl[2] = mk(0, 7, 1);
    tbl[3] = mk(4, 4, 8);  tbl[4] = mk(0, 0, 0);  tbl[5] = mk(2, 5, 5);
  endtask

  // Drives one frame (start at k=0) and records outputs at each negedge+1.
  task automatic run_frame(input int stall_lo, input int stall_hi, input int rst_k,
                           input int x1, input int x2, input int nk);
    for (int k = 0; k < nk; k++) begin
      @(negedge clk);
      start     = (k == 0) || (k == x1) || (k == x2);
      row_valid = !((k >= stall_lo) && (k <= stall_hi));
      reset     = !((k >= rst_k) && (k <= rst_k + 1));
      #1;
      h_rd[k] = rd_a;  h_stb[k] = stb_a;  h_busy[k] = busy_a;  h_done[k] = done_a;
      h_mv[k] = mv_a;  h_cnt[k] = cnt_a;  h_mvb[k] = mv_b;     h_stbb[k] = stb_b;
    end
    @(negedge clk);
    start = 1'b0;
    row_valid = 1'b1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++;
    if ({rd_a, stb_a, mv_a, cnt_a, busy_a, done_a} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: got %b expected 0", {rd_a, stb_a, mv_a, cnt_a, busy_a, done_a});
    end
    n_checks++;
    if ({rd_b, stb_b, mv_b, cnt_b, busy_b, done_b} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got %b expected 0", {rd_b, stb_b, mv_b, cnt_b, busy_b, done_b});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b expected 0", busy_a);
    end
  endtask

  task automatic test_frame();
    int exp_mv [6];
    int n;
    int nd;
    int dk;
    exp_mv = '{2, 0, 1, 2, 0, 1};
    load_main();
    run_frame(100, 100, 100, -1, -1, 40);
    n = 0; nd = 0; dk = -1;
    for (int k = 0; k < 40; k++) begin
      if (h_stb[k] && n < 6) begin
        n_checks++;
        if (h_mv[k] !== exp_mv[n][1:0] || h_cnt[k] !== n[2:0] || k != 5 + 5 * n) begin
          n_fail++;
          $display("FAIL frame_row%0d: mv=%0d cnt=%0d cyc=%0d expected mv=%0d cnt=%0d cyc=%0d",
                   n, h_mv[k], h_cnt[k], k, exp_mv[n], n, 5 + 5 * n);
        end
        n++;
      end
      if (h_done[k]) begin nd++; dk = k; end
    end
    n_checks++;
    if (n != 6) begin n_fail++; $display("FAIL frame_strobes: got %0d expected 6", n); end
    n_checks++;
    if (nd != 1 || dk != 31) begin
      n_fail++;
      $display("FAIL frame_done: count=%0d cyc=%0d expected 1 at 31", nd, dk);
    end
    n_checks++;
    if (h_busy[3] !== 1'b1 || h_rd[3] !== 1'b1 || h_rd[5] !== 1'b0 || h_busy[32] !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_busy_rd: busy3=%b rd3=%b rd5=%b busy32=%b expected 1 1 0 0",
               h_busy[3], h_rd[3], h_rd[5], h_busy[32]);
    end
    n_checks++;
    if (h_cnt[35] !== 3'd5) begin
      n_fail++;
      $display("FAIL counter_hold: got %0d expected 5", h_cnt[35]);
    end
  endtask

  task automatic test_ties();
    int exp_mv [6];
    int n;
    exp_mv = '{0, 1, 2, 2, 0, 0};
    tbl[0] = mk(5, 5, 5);  tbl[1] = mk(1, 9, 9);  tbl[2] = mk(3, 3, 7);
    tbl[3] = mk(0, 0, 1);  tbl[4] = mk(2, 1, 0);  tbl[5] = mk(6, 6, 6);
    run_frame(100, 100, 100, -1, -1, 40);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (h_stb[k] && n < 6) begin
        n_checks++;
        if (h_mv[k] !== exp_mv[n][1:0]) begin
          n_fail++;
          $display("FAIL ties_row%0d: got %0d expected %0d", n, h_mv[k], exp_mv[n]);
        end
        n++;
      end
    end
    n_checks++;
    if (n != 6) begin n_fail++; $display("FAIL ties_strobes: got %0d expected 6", n); end
  endtask

  task automatic test_signed();
    tbl[0] = mk(32'hFFFF, 32'h0001, 32'h8000);
    for (int i = 1; i < 6; i++) tbl[i] = mk(1, 2, 3);
    run_frame(100, 100, 100, -1, -1, 40);
    n_checks++;
    if (h_stb[5] !== 1'b1 || h_mv[5] !== 2'd0) begin
      n_fail++;
      $display("FAIL unsigned_cmp: stb=%b mv=%0d expected 1 0", h_stb[5], h_mv[5]);
    end
    n_checks++;
    if (h_stbb[5] !== 1'b1 || h_mvb[5] !== 2'd1) begin
      n_fail++;
      $display("FAIL signed_cmp: stb=%b mv=%0d expected 1 1", h_stbb[5], h_mvb[5]);
    end
    n_checks++;
    if (h_mv[10] !== 2'd2 || h_mvb[10] !== 2'd2) begin
      n_fail++;
      $display("FAIL cmp_row1: a=%0d b=%0d expected 2 2", h_mv[10], h_mvb[10]);
    end
  endtask

  task automatic test_stall();
    int exp_k [6];
    int n;
    int dk;
    exp_k = '{5, 10, 18, 23, 28, 33};
    load_main();
    run_frame(11, 13, 100, -1, -1, 40);
    for (int k = 11; k <= 13; k++) begin
      n_checks++;
      if (h_rd[k] !== 1'b1 || h_stb[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_c%0d: rd=%b stb=%b expected 1 0", k, h_rd[k], h_stb[k]);
      end
    end
    n = 0; dk = -1;
    for (int k = 0; k < 40; k++) begin
      if (h_stb[k] && n < 6) begin
        n_checks++;
        if (k != exp_k[n] || h_cnt[k] !== n[2:0]) begin
          n_fail++;
          $display("FAIL stall_row%0d: cyc=%0d cnt=%0d expected cyc=%0d cnt=%0d",
                   n, k, h_cnt[k], exp_k[n], n);
        end
        n++;
      end
      if (h_done[k]) dk = k;
    end
    n_checks++;
    if (h_mv[18] !== 2'd1) begin
      n_fail++;
      $display("FAIL stall_result: got %0d expected 1", h_mv[18]);
    end
    n_checks++;
    if (dk != 34) begin n_fail++; $display("FAIL stall_done: cyc=%0d expected 34", dk); end
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    load_main();
    run_frame(100, 100, 18, -1, -1, 40);
    n_checks++;
    if ({h_rd[18], h_stb[18], h_mv[18], h_cnt[18], h_busy[18], h_done[18]} !== 9'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b expected 0",
               {h_rd[18], h_stb[18], h_mv[18], h_cnt[18], h_busy[18], h_done[18]});
    end
    n = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (h_stb[k]) n++;
      if (k >= 18 && (h_stb[k] || h_done[k] || h_busy[k])) bad++;
    end
    n_checks++;
    if (n != 3 || bad != 0) begin
      n_fail++;
      $display("FAIL midreset_activity: strobes=%0d late=%0d expected 3 0", n, bad);
    end
    run_frame(100, 100, 100, -1, -1, 40);
    n_checks++;
    if (h_stb[5] !== 1'b1 || h_cnt[5] !== 3'd0 || h_mv[5] !== 2'd2) begin
      n_fail++;
      $display("FAIL restart_first: stb=%b cnt=%0d mv=%0d expected 1 0 2",
               h_stb[5], h_cnt[5], h_mv[5]);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    int nd;
    int bad;
    load_main();
    run_frame(100, 100, 100, 3, 31, 40);
    n = 0; nd = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (h_stb[k]) begin
        if (h_cnt[k] !== n[2:0] || k != 5 + 5 * n) bad++;
        n++;
      end
      if (h_done[k]) nd++;
    end
    n_checks++;
    if (n != 6 || bad != 0) begin
      n_fail++;
      $display("FAIL start_ignored_path: strobes=%0d bad=%0d expected 6 0", n, bad);
    end
    n_checks++;
    if (nd != 1 || h_done[31] !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignored_done: count=%0d done31=%b expected 1 1", nd, h_done[31]);
    end
    n_checks++;
    if (h_busy[33] !== 1'b0 || h_busy[39] !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_done: busy33=%b busy39=%b expected 0 0", h_busy[33], h_busy[39]);
    end
  endtask

  initial begin
    load_main();
    repeat (2) @(negedge clk);
    test_reset();
    test_frame();
    test_ties();
    test_signed();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
